// File: rtl/acc_stream_tx_pkg.sv
// Shared state encoding and default widths for the accumulator transmit path.
package acc_stream_tx_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int BUFFER_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEND,
        ST_WAIT_RES,
        ST_DONE
    } state_e;

endpackage

// File: rtl/acc_stream_tx_if.sv
// Host, accumulator-stream and result signals of acc_stream_tx.
// The master side drives requests and data; the slave side is the transmit block.
interface acc_stream_tx_if import acc_stream_tx_pkg::*; #(
    parameter int DataWidth       = DATA_WIDTH,
    parameter int GroupCountWidth = 8
) ();

    logic                       Start;
    logic [GroupCountWidth-1:0] GroupCount;
    logic                       HostValid;
    logic [DataWidth-1:0]       HostData;
    logic                       HostRdy;
    logic                       TxValid;
    logic [DataWidth-1:0]       TxData;
    logic                       TxRdy;
    logic                       AccSclr;
    logic                       ResultValid;
    logic [DataWidth-1:0]       ResultData;
    logic                       ResultOutValid;
    logic [DataWidth-1:0]       ResultOut;
    logic                       Busy;
    logic                       Done;

    modport master (
        output Start, GroupCount, HostValid, HostData, TxRdy, ResultValid, ResultData,
        input  HostRdy, TxValid, TxData, AccSclr, ResultOutValid, ResultOut, Busy, Done
    );

    modport slave (
        input  Start, GroupCount, HostValid, HostData, TxRdy, ResultValid, ResultData,
        output HostRdy, TxValid, TxData, AccSclr, ResultOutValid, ResultOut, Busy, Done
    );

endinterface

// File: rtl/acc_tx_fifo.sv
// Synchronous FIFO with registered full/empty; a pushed word reaches the head one cycle later.
// Push at full and pop at empty are ignored, so callers may strobe without pre-qualifying.
module acc_tx_fifo import acc_stream_tx_pkg::*; #(
    parameter int DataWidth   = DATA_WIDTH,
    parameter int BufferWidth = BUFFER_WIDTH,
    parameter int BufferSize  = 2 ** BufferWidth
) (
    input  logic                 clk,
    input  logic                 sclr_n,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_dat_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_dat_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DataWidth-1:0]   mem_q [BufferSize];
    logic [BufferWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [BufferWidth:0]   count_q, count_d;
    logic                   full_q, empty_q;
    logic                   push, pop;

    assign push       = push_i & ~full_q;
    assign pop        = pop_i & ~empty_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (BufferWidth + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (BufferWidth + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < BufferSize; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + BufferWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + BufferWidth'(1);
            end
            count_q <= count_d;
            // count never exceeds the depth, so its MSB alone marks full
            full_q  <= count_d[BufferWidth];
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/acc_stream_tx.sv
// Streams buffered host words into the accumulator in groups and counts returned results.
// Results are re-registered with 1-cycle latency; TxValid holds under TxRdy backpressure, HostRdy drops at full.
module acc_stream_tx import acc_stream_tx_pkg::*; #(
    parameter int DataWidth            = DATA_WIDTH,
    parameter int BufferWidth          = BUFFER_WIDTH,
    parameter int BufferSize           = 2 ** BufferWidth,
    parameter int AccumulateCount      = 2,
    parameter int AccumulateCountWidth = 1,
    parameter int GroupCountWidth      = 8
) (
    input  logic            clk,
    input  logic            sclr_n,
    acc_stream_tx_if.slave  bus
);

    localparam logic [AccumulateCountWidth-1:0] ElemLast =
        AccumulateCountWidth'(AccumulateCount - 1);

    state_e                          state_q, state_d;
    logic [AccumulateCountWidth-1:0] elem_cnt_q, elem_cnt_d;
    logic [GroupCountWidth-1:0]      group_cnt_q, group_cnt_d;
    logic [GroupCountWidth-1:0]      result_cnt_q, result_cnt_d;
    logic [GroupCountWidth-1:0]      group_total_q, group_total_d;
    logic                            res_vld_q, res_vld_d;
    logic [DataWidth-1:0]            res_dat_q, res_dat_d;
    logic [DataWidth-1:0]            head_dat;
    logic                            fifo_full, fifo_empty;
    logic                            push, pop, tx_vld;

    acc_tx_fifo #(
        .DataWidth  (DataWidth),
        .BufferWidth(BufferWidth),
        .BufferSize (BufferSize)
    ) u_fifo (
        .clk       (clk),
        .sclr_n    (sclr_n),
        .push_i    (push),
        .push_dat_i(bus.HostData),
        .pop_i     (pop),
        .head_dat_o(head_dat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign push   = bus.HostValid & ~fifo_full;
    assign tx_vld = (state_q == ST_SEND) & ~fifo_empty;
    assign pop    = tx_vld & bus.TxRdy;

    assign bus.HostRdy        = ~fifo_full;
    assign bus.TxValid        = tx_vld;
    assign bus.TxData         = head_dat;
    assign bus.AccSclr        = (state_q == ST_CLEAR);
    assign bus.Busy           = (state_q != ST_IDLE);
    assign bus.Done           = (state_q == ST_DONE);
    assign bus.ResultOutValid = res_vld_q;
    assign bus.ResultOut      = res_dat_q;

    always_comb begin
        state_d       = state_q;
        elem_cnt_d    = elem_cnt_q;
        group_cnt_d   = group_cnt_q;
        result_cnt_d  = result_cnt_q;
        group_total_d = group_total_q;
        res_vld_d     = 1'b0;
        res_dat_d     = res_dat_q;

        // results are only meaningful once the accumulator has been cleared for this job
        if ((state_q == ST_SEND || state_q == ST_WAIT_RES) && bus.ResultValid) begin
            res_vld_d    = 1'b1;
            res_dat_d    = bus.ResultData;
            result_cnt_d = result_cnt_q + GroupCountWidth'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (bus.GroupCount != '0) begin
                        group_total_d = bus.GroupCount;
                        state_d       = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                elem_cnt_d   = '0;
                group_cnt_d  = '0;
                result_cnt_d = '0;
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                if (pop) begin
                    if (elem_cnt_q == ElemLast) begin
                        elem_cnt_d  = '0;
                        group_cnt_d = group_cnt_q + GroupCountWidth'(1);
                        if (group_cnt_d == group_total_q) begin
                            state_d = ST_WAIT_RES;
                        end
                    end else begin
                        elem_cnt_d = elem_cnt_q + AccumulateCountWidth'(1);
                    end
                end
            end
            ST_WAIT_RES: begin
                if (result_cnt_q == group_total_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q       <= ST_IDLE;
            elem_cnt_q    <= '0;
            group_cnt_q   <= '0;
            result_cnt_q  <= '0;
            group_total_q <= '0;
            res_vld_q     <= 1'b0;
            res_dat_q     <= '0;
        end else begin
            state_q       <= state_d;
            elem_cnt_q    <= elem_cnt_d;
            group_cnt_q   <= group_cnt_d;
            result_cnt_q  <= result_cnt_d;
            group_total_q <= group_total_d;
            res_vld_q     <= res_vld_d;
            res_dat_q     <= res_dat_d;
        end
    end

endmodule

// File: tb/tb_acc_stream_tx.sv
// Bench for acc_stream_tx: directed scenarios plus random traffic against a queue-based job model.
module tb_acc_stream_tx;

    localparam int DW  = 32;
    localparam int GCW = 8;
    localparam int AC  = 2;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_SEND  = 2;
    localparam int P_WAIT  = 3;
    localparam int P_DONE  = 4;

    logic clk    = 1'b0;
    logic sclr_n = 1'b0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    acc_stream_tx_if #(.DataWidth(DW), .GroupCountWidth(GCW)) bus ();

    acc_stream_tx #(
        .DataWidth           (DW),
        .BufferWidth         (2),
        .BufferSize          (4),
        .AccumulateCount     (AC),
        .AccumulateCountWidth(1),
        .GroupCountWidth     (GCW)
    ) dut (
        .clk   (clk),
        .sclr_n(sclr_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Job-level model: FIFO contents, words still owed, results received so far.
    logic [31:0] m_q [$];
    int          m_phase     = P_IDLE;
    int          m_words_left = 0;
    int          m_res_got   = 0;
    int          m_gc        = 0;
    logic        m_res_vld   = 1'b0;
    logic [31:0] m_res_dat   = '0;

    always @(posedge clk) begin : model
        bit full, txv, psh, pp;
        int nxt;
        if (!sclr_n) begin
            m_q.delete();
            m_phase = P_IDLE; m_words_left = 0; m_res_got = 0; m_gc = 0;
            m_res_vld = 1'b0; m_res_dat = '0;
        end else begin
            full = (m_q.size() == 4);
            txv  = (m_phase == P_SEND) && (m_q.size() > 0);
            psh  = bus.HostValid && !full;
            pp   = txv && bus.TxRdy;
            nxt  = m_phase;
            case (m_phase)
                P_IDLE:  if (bus.Start) begin
                             if (bus.GroupCount != 0) begin m_gc = int'(bus.GroupCount); nxt = P_CLEAR; end
                             else nxt = P_DONE;
                         end
                P_CLEAR: begin m_words_left = m_gc * AC; m_res_got = 0; nxt = P_SEND; end
                P_SEND:  if (pp) begin m_words_left--; if (m_words_left == 0) nxt = P_WAIT; end
                P_WAIT:  if (m_res_got == m_gc) nxt = P_DONE;
                default: nxt = P_IDLE;
            endcase
            if ((m_phase == P_SEND || m_phase == P_WAIT) && bus.ResultValid) begin
                m_res_vld = 1'b1; m_res_dat = bus.ResultData; m_res_got = (m_res_got + 1) % 256;
            end else begin
                m_res_vld = 1'b0;
            end
            if (pp) void'(m_q.pop_front());
            if (psh) m_q.push_back(bus.HostData);
            m_phase = nxt;
        end
    end

    always @(negedge clk) begin : compare
        bit etx;
        if (chk_en) begin
            etx = (m_phase == P_SEND) && (m_q.size() > 0);
            chk("HostRdy", 32'(bus.HostRdy), 32'(m_q.size() < 4));
            chk("TxValid", 32'(bus.TxValid), 32'(etx));
            if (etx) chk("TxData", bus.TxData, m_q[0]);
            chk("AccSclr", 32'(bus.AccSclr), 32'(m_phase == P_CLEAR));
            chk("Busy", 32'(bus.Busy), 32'(m_phase != P_IDLE));
            chk("Done", 32'(bus.Done), 32'(m_phase == P_DONE));
            chk("ResultOutValid", 32'(bus.ResultOutValid), 32'(m_res_vld));
            chk("ResultOut", bus.ResultOut, m_res_dat);
        end
    end

    // Observed handshakes and pulses, counted from the DUT side.
    logic [31:0] tx_log [$];
    int n_sclr = 0;
    int n_done = 0;
    always @(negedge clk) begin : monitor
        if (sclr_n && bus.TxValid && bus.TxRdy) tx_log.push_back(bus.TxData);
        if (sclr_n && bus.AccSclr) n_sclr++;
        if (sclr_n && bus.Done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.HostValid = 1'b1; bus.HostData = d;
        tick();
        bus.HostValid = 1'b0;
    endtask

    task automatic start_job(input int gc);
        bus.Start = 1'b1; bus.GroupCount = GCW'(gc);
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_log.size() < n && k < 60) begin tick(); k++; end
        chk("tx_count", 32'(tx_log.size()), 32'(n));
    endtask

    task automatic give_result(input logic [31:0] d);
        bus.ResultValid = 1'b1; bus.ResultData = d;
        tick();
        bus.ResultValid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int k = 0;
        while (n_done == prev && k < 60) begin tick(); k++; end
        tick(); tick();
        chk("done_pulses", 32'(n_done - prev), 32'd1);
        chk("idle_after_done", 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_basic [4];
        logic [31:0] w [4];
        logic [31:0] hold;
        int base, prev, sprev;

        exp_basic[0] = 32'h3F800000; exp_basic[1] = 32'h40000000;
        exp_basic[2] = 32'h40400000; exp_basic[3] = 32'h40800000;
        bus.Start = 0; bus.GroupCount = '0; bus.HostValid = 0; bus.HostData = '0;
        bus.TxRdy = 0; bus.ResultValid = 0; bus.ResultData = '0;

        // reset then idle, fill FIFO, refused fifth push
        sclr_n = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_txvalid", 32'(bus.TxValid), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_hostrdy", 32'(bus.HostRdy), 32'd1);
        sclr_n = 1'b1;
        for (int i = 0; i < 4; i++) push_word(exp_basic[i]);
        chk("full_hostrdy", 32'(bus.HostRdy), 32'd0);
        push_word(32'hDEADBEEF);
        chk("refused_hostrdy", 32'(bus.HostRdy), 32'd0);

        // basic job
        bus.TxRdy = 1'b1;
        prev = n_done; sprev = n_sclr;
        start_job(2);
        wait_tx(4);
        for (int i = 0; i < 4; i++) chk("basic_order", tx_log[i], exp_basic[i]);
        chk("basic_sclr", 32'(n_sclr - sprev), 32'd1);
        give_result(32'h40400000);
        chk("res1_vld", 32'(bus.ResultOutValid), 32'd1);
        chk("res1_dat", bus.ResultOut, 32'h40400000);
        give_result(32'h40E00000);
        chk("res2_vld", 32'(bus.ResultOutValid), 32'd1);
        chk("res2_dat", bus.ResultOut, 32'h40E00000);
        wait_done(prev);

        // backpressure mid-SEND, with an ignored Start
        for (int i = 0; i < 4; i++) begin w[i] = $urandom; push_word(w[i]); end
        base = tx_log.size(); prev = n_done;
        start_job(2);
        wait_tx(base + 1);
        bus.TxRdy = 1'b0;
        hold = bus.TxData;
        chk("bp_head", hold, w[1]);
        for (int i = 0; i < 5; i++) begin
            bus.Start = (i == 2); bus.GroupCount = 8'd5;
            tick();
            chk("bp_vld", 32'(bus.TxValid), 32'd1);
            chk("bp_dat", bus.TxData, hold);
        end
        bus.Start = 1'b0;
        bus.TxRdy = 1'b1;
        wait_tx(base + 4);
        for (int i = 0; i < 4; i++) chk("bp_order", tx_log[base + i], w[i]);
        give_result($urandom); give_result($urandom);
        wait_done(prev);

        // underflow mid-job
        base = tx_log.size(); prev = n_done;
        for (int i = 0; i < 2; i++) begin w[i] = $urandom; push_word(w[i]); end
        start_job(2);
        wait_tx(base + 2);
        tick(); tick(); tick();
        chk("uf_txvalid", 32'(bus.TxValid), 32'd0);
        chk("uf_busy", 32'(bus.Busy), 32'd1);
        for (int i = 2; i < 4; i++) begin w[i] = $urandom; push_word(w[i]); end
        wait_tx(base + 4);
        for (int i = 0; i < 4; i++) chk("uf_order", tx_log[base + i], w[i]);
        give_result($urandom); give_result($urandom);
        wait_done(prev);

        // GroupCount=0
        prev = n_done; sprev = n_sclr;
        start_job(0);
        chk("gc0_done", 32'(bus.Done), 32'd1);
        tick();
        chk("gc0_sclr", 32'(n_sclr - sprev), 32'd0);
        chk("gc0_busy", 32'(bus.Busy), 32'd0);

        // ResultValid while idle is dropped
        give_result(32'h12345678);
        chk("idle_res_vld", 32'(bus.ResultOutValid), 32'd0);

        // reset mid-job
        bus.TxRdy = 1'b0;
        push_word($urandom); push_word($urandom);
        start_job(3);
        tick(); tick();
        chk("mid_txvalid", 32'(bus.TxValid), 32'd1);
        sclr_n = 1'b0;
        tick();
        sclr_n = 1'b1;
        chk("mrst_txvalid", 32'(bus.TxValid), 32'd0);
        chk("mrst_busy", 32'(bus.Busy), 32'd0);
        chk("mrst_hostrdy", 32'(bus.HostRdy), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.HostValid   = ($urandom_range(0, 9) < 6);
            bus.HostData    = $urandom;
            bus.TxRdy       = ($urandom_range(0, 9) < 7);
            bus.Start       = ($urandom_range(0, 9) == 0);
            bus.GroupCount  = GCW'($urandom_range(0, 3));
            bus.ResultValid = (m_phase == P_SEND || m_phase == P_WAIT) && (m_res_got < m_gc)
                              && ($urandom_range(0, 3) == 0);
            bus.ResultData  = $urandom;
            sclr_n          = ($urandom_range(0, 499) != 0);
            tick();
        end
        bus.HostValid = 0; bus.Start = 0; bus.ResultValid = 0; sclr_n = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/acc_stream_tx.md
Name: acc_stream_tx

Overview:
- Transmit-side companion to the floating-point accumulator.
- Buffers operand words pushed by a host and streams them into the accumulator's valid/ready input in groups of AccumulateCount words.
- Pulses the accumulator's synchronous clear before each job and counts returned group results. Completion is signalled once every result of the job has come back.

Parameters:
- DataWidth, 32, operand/result word width.
- BufferWidth, 2, FIFO pointer width.
- BufferSize, 4, FIFO depth (2**BufferWidth).
- AccumulateCount, 2, words per group; must match the accumulator.
- AccumulateCountWidth, 1, width of the in-group word counter.
- GroupCountWidth, 8, width of the per-job group count.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- sclr_n  in  1  synchronous active-low reset.
- Start  in  1  job start request; sampled only in IDLE.
- GroupCount  in  GroupCountWidth  groups in the job; latched on accepted Start.
- HostValid  in  1  host word valid.
- HostData  in  DataWidth  host word.
- HostRdy  out  1  FIFO can accept a word (~Full).
- TxValid  out  1  word offered to the accumulator.
- TxData  out  DataWidth  FIFO head word.
- TxRdy  in  1  accumulator ready (its DataInRdy).
- AccSclr  out  1  clear pulse to the accumulator.
- ResultValid  in  1  accumulator DataOutValid.
- ResultData  in  DataWidth  accumulator DataOut.
- ResultOutValid  out  1  registered result valid.
- ResultOut  out  DataWidth  registered result.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset (sclr_n=0 at an edge):
  - State goes to IDLE and the FIFO is flushed (empty).
  - All counters are cleared.
  - All outputs are 0, except HostRdy=1.
  - Reset during a job abandons the job. This is the only case in which TxValid may fall without a handshake.
- FIFO:
  - Push = HostValid & HostRdy. Pop = TxValid & TxRdy.
  - Full/empty are registered. No push at full, no pop at empty, no push-to-pop bypass: a word pushed into an empty FIFO is visible on TxData the next cycle.
  - Simultaneous push and pop: the count is unchanged and both occur.
  - Pointers wrap modulo BufferSize.
- States and transitions:
  - IDLE:
    - Start=1 and GroupCount!=0: latch GroupCount, go to CLEAR.
    - Start=1 and GroupCount=0: go to DONE.
    - Otherwise stay.
    - The FIFO may fill while in IDLE.
  - CLEAR: AccSclr=1 and TxValid=0 for exactly one cycle. Reset the element, group and result counters, then go to SEND.
  - SEND:
    - TxValid = ~Empty. TxData = FIFO head.
    - On each pop, the element counter increments modulo AccumulateCount. When it wraps, the group counter increments.
    - On the pop that completes group GroupCount, go to WAIT_RES.
    - Once asserted, TxValid and TxData stay stable until accepted.
  - WAIT_RES: TxValid=0. When the result counter reaches the latched GroupCount, go to DONE.
  - DONE: Done=1 for one cycle, then go to IDLE.
- Results:
  - In SEND and WAIT_RES, each ResultValid=1 increments the result counter. Next cycle, ResultOutValid=1 and ResultOut=ResultData (latency 1).
  - A result arriving in the same cycle as the last group's pop is counted.
  - ResultValid in IDLE, CLEAR or DONE is dropped, with no output.
  - ResultOut holds its last value when ResultOutValid=0.
- Start while Busy is ignored.
- Host words left in the FIFO after a job carry over to the next job.
- Counters are sized exactly: element counter AccumulateCountWidth bits, group and result counters GroupCountWidth bits. Comparison is against the latched GroupCount.

Decomposition:
- Shared package: the state encoding (IDLE, CLEAR, SEND, WAIT_RES, DONE) and the default DataWidth/BufferWidth constants used by the accumulator path.
- One natural sub-module: acc_tx_fifo, a synchronous FIFO with sclr_n, registered Full/Empty, head word output, and push/pop strobes. The FSM and counters live in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: hold sclr_n=0 for 2 cycles.
  - Required: TxValid=0, Busy=0, Done=0, HostRdy=1. After 4 pushes HostRdy=0; a 5th push is refused.
- Basic job:
  - Stimulus: push 1.0, 2.0, 3.0, 4.0 (FP32 0x3F800000, 0x40000000, 0x40400000, 0x40800000). Start with GroupCount=2.
  - Required: AccSclr for 1 cycle, then four TxValid handshakes in push order.
  - Feed ResultValid with 0x40400000 then 0x40E00000: ResultOut shows each value 1 cycle later. Done pulses once, then Busy=0.
- Backpressure:
  - Stimulus: TxRdy=0 for 5 cycles in the middle of SEND.
  - Required: TxValid held at 1 and TxData constant throughout. No word is lost or duplicated.
- FIFO underflow mid-job:
  - Stimulus: GroupCount=2 with only 2 words pushed.
  - Required: TxValid drops to 0 after 2 words, and the state stays SEND. Pushing 2 more words resumes sending, and the job completes.
- Edge cases:
  - GroupCount=0 gives Done on the cycle after Start, with no AccSclr.
  - Start asserted during SEND is ignored.
  - ResultValid asserted in IDLE produces no ResultOutValid.
- Reset mid-job:
  - Stimulus: sclr_n=0 during SEND.
  - Required: state IDLE, FIFO empty, TxValid=0, Busy=0 on the next cycle.
